// File: rtl/alloc_pkg.sv
// Shared types for the free-list allocator: chain descriptor for whole-chain frees
// and the width of the free counter.
package alloc_pkg;

  localparam int ADDR_W  = 4;
  localparam int COUNT_W = ADDR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  head;
    logic [ADDR_W-1:0]  second;
    logic [ADDR_W-1:0]  tail;
    logic [COUNT_W-1:0] count;
  } vec_t;

endpackage

// File: rtl/bram.sv
// Dual-port link RAM: port A synchronous read, port B write. Contents are loaded at
// configuration with entry i pointing to (i+INIT_STRIDE) mod DEPTH; reset never clears it.
module bram #(
  parameter int AW          = 4,
  parameter int DW          = 4,
  parameter int DEPTH       = 16,
  parameter int INIT_STRIDE = 1
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata
);

  typedef logic [DW-1:0] mem_t [DEPTH];

  function automatic mem_t init_links();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DW'((((i + INIT_STRIDE) % DEPTH) + DEPTH) % DEPTH);
    end
    return m;
  endfunction

  mem_t mem_r = init_links();

  // port B write
  always_ff @(posedge clk) begin
    if (b_en) mem_r[b_addr] <= b_wdata;
  end

  // port A read (old data on collision; forwarding is handled outside)
  always_ff @(posedge clk) begin
    if (a_en) a_rdata <= mem_r[a_addr];
  end

endmodule

// File: rtl/link_fwd.sv
// Next-head bypass: presents either the link word read last cycle (with same-cycle
// write forwarding) or an explicitly loaded value, and captures it so it holds afterwards.
module link_fwd #(
  parameter int AW       = 4,
  parameter int RST_NEXT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic [AW-1:0] ram_rdata,
  input  logic          load_en,
  input  logic [AW-1:0] load_val,
  input  logic          load_ram,
  output logic [AW-1:0] next_addr
);

  logic          fwd_r;
  logic [AW-1:0] fwd_data_r;
  logic          sel_ram_r;
  logic [AW-1:0] next_r;
  logic [AW-1:0] rd_data_s;

  assign rd_data_s = fwd_r ? fwd_data_r : ram_rdata;
  assign next_addr = sel_ram_r ? rd_data_s : next_r;

  // forwarding flag and bypass register
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_r      <= 1'b0;
      fwd_data_r <= '0;
      sel_ram_r  <= 1'b0;
      next_r     <= AW'(RST_NEXT);
    end else begin
      fwd_r      <= rd_en && wr_en && (rd_addr == wr_addr);
      fwd_data_r <= wr_data;
      sel_ram_r  <= load_ram;
      next_r     <= load_en ? load_val : next_addr;
    end
  end

endmodule

// File: rtl/free_list_allocator.sv
// In-order free-list allocator with single/chain free and checkpoint rewind.
// Optional sticky error checking is enabled by defining ALLOC_ERR_EN.
module free_list_allocator
  import alloc_pkg::*;
#(
  parameter int ADDR         = ADDR_W,
  parameter int DEPTH        = 16,
  parameter int DIRECTION    = 1,
  parameter int INITIAL_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [ADDR-1:0] alloc_addr,
  input  logic            free_valid,
  output logic            free_ready,
  input  logic [ADDR-1:0] free_addr,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  vec_t            vec,
  input  logic            rewind,
  input  logic [ADDR-1:0] rewind_addr,
  input  logic [ADDR:0]   rewind_count,
  output logic [ADDR:0]   free_count,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam int CW       = ADDR + 1;
  localparam int RST_NEXT = (((INITIAL_ADDR + DIRECTION) % DEPTH) + DEPTH) % DEPTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR-1:0] head_r, head_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic            bubble_r, bubble_n;
  logic            ready_r, empty_r, full_r;
  logic [ADDR-1:0] next_s, link_val_s;
  logic            alloc_fire_s, free_fire_s, vec_fire_s, rewind_fire_s, err_set_s;
  logic            rd_en_s, wr_en_s, nxt_ld_s, nxt_ram_s;
  logic [ADDR-1:0] rd_addr_s, wr_addr_s, wr_data_s, nxt_val_s, ram_rdata_s;

  assign alloc_ready = ready_r;
  assign alloc_addr  = head_r;
  assign free_count  = cnt_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign free_ready  = !vec_valid && !rewind;
  assign vec_ready   = !rewind;

`ifdef ALLOC_ERR_EN
  logic [CW:0] gain_s, sum_s;
  logic        ovf_s, rew_bad_s;

  // legality checks; an offending operation is dropped
  always_comb begin
    gain_s        = vec_valid ? {1'b0, vec.count} : (free_valid ? (CW+1)'(1) : (CW+1)'(0));
    alloc_fire_s  = alloc_valid && ready_r && !rewind;
    sum_s         = {1'b0, cnt_r} + gain_s - (CW+1)'(alloc_fire_s);
    ovf_s         = sum_s > {1'b0, DEPTH_C};
    rew_bad_s     = rewind && (rewind_count > DEPTH_C);
    vec_fire_s    = vec_valid && !rewind && !ovf_s;
    free_fire_s   = free_valid && !vec_valid && !rewind && !ovf_s;
    rewind_fire_s = rewind && !rew_bad_s;
    err_set_s     = (alloc_valid && empty_r) || (!rewind && ovf_s) || rew_bad_s;
  end
`else
  // handshake fires; rewind cancels everything else
  always_comb begin
    alloc_fire_s  = alloc_valid && ready_r && !rewind;
    vec_fire_s    = vec_valid && !rewind;
    free_fire_s   = free_valid && !vec_valid && !rewind;
    rewind_fire_s = rewind;
    err_set_s     = 1'b0;
  end
`endif

  // freed tail links to the old head, or to old next when the old head is allocated now
  assign link_val_s = alloc_fire_s ? next_s : head_r;

  // next-state for head, counter, link writes and next-head source
  always_comb begin
    head_n    = head_r;
    cnt_n     = cnt_r;
    bubble_n  = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = next_s;
    wr_en_s   = 1'b0;
    wr_addr_s = free_addr;
    wr_data_s = link_val_s;
    nxt_ld_s  = 1'b0;
    nxt_val_s = link_val_s;
    nxt_ram_s = 1'b0;
    if (rewind_fire_s) begin
      head_n    = rewind_addr;
      cnt_n     = rewind_count;
      rd_en_s   = 1'b1;
      rd_addr_s = rewind_addr;
      nxt_ram_s = 1'b1;
      bubble_n  = 1'b1;
    end else if (vec_fire_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = vec.tail;
      head_n    = vec.head;
      nxt_ld_s  = 1'b1;
      nxt_val_s = (vec.count == CW'(1)) ? link_val_s : vec.second;
      cnt_n     = cnt_r + vec.count - CW'(alloc_fire_s);
    end else if (free_fire_s) begin
      wr_en_s   = 1'b1;
      head_n    = free_addr;
      nxt_ld_s  = 1'b1;
      cnt_n     = alloc_fire_s ? cnt_r : cnt_r + CW'(1);
    end else if (alloc_fire_s) begin
      head_n    = next_s;
      rd_en_s   = 1'b1;
      nxt_ram_s = 1'b1;
      cnt_n     = cnt_r - CW'(1);
    end else begin
      head_n    = head_r;
    end
  end

  // state and registered flags
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r   <= ADDR'(INITIAL_ADDR);
      cnt_r    <= DEPTH_C;
      bubble_r <= 1'b0;
      ready_r  <= 1'b1;
      empty_r  <= 1'b0;
      full_r   <= 1'b1;
    end else begin
      head_r   <= head_n;
      cnt_r    <= cnt_n;
      bubble_r <= bubble_n;
      ready_r  <= (cnt_n != CW'(0)) && !bubble_n;
      empty_r  <= cnt_n == CW'(0);
      full_r   <= cnt_n == DEPTH_C;
    end
  end

`ifdef ALLOC_ERR_EN
  logic err_r;

  // sticky error
  always_ff @(posedge clk) begin
    if (reset) err_r <= 1'b0;
    else       err_r <= err_r || err_set_s;
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  bram #(
    .AW(ADDR), .DW(ADDR), .DEPTH(DEPTH), .INIT_STRIDE(DIRECTION)
  ) u_link_ram (
    .clk     (clk),
    .a_en    (rd_en_s),
    .a_addr  (rd_addr_s),
    .a_rdata (ram_rdata_s),
    .b_en    (wr_en_s),
    .b_addr  (wr_addr_s),
    .b_wdata (wr_data_s)
  );

  link_fwd #(
    .AW(ADDR), .RST_NEXT(RST_NEXT)
  ) u_link_fwd (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en_s),
    .rd_addr   (rd_addr_s),
    .wr_en     (wr_en_s),
    .wr_addr   (wr_addr_s),
    .wr_data   (wr_data_s),
    .ram_rdata (ram_rdata_s),
    .load_en   (nxt_ld_s),
    .load_val  (nxt_val_s),
    .load_ram  (nxt_ram_s),
    .next_addr (next_s)
  );

endmodule

// File: tb/tb_free_list_allocator.sv
// Bench for free_list_allocator: the free list is modelled as an ordered queue of
// addresses; each allocated entry remembers the entry that followed it when it left.
module tb_free_list_allocator;
  import alloc_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid = 1'b0, free_valid = 1'b0, vec_valid = 1'b0, rewind = 1'b0;
  logic        alloc_ready, free_ready, vec_ready, empty, full, err;
  logic [3:0]  alloc_addr, free_addr = 4'd0, rewind_addr = 4'd0;
  logic [4:0]  rewind_count = 5'd0, free_count;
  vec_t        vec = '0;

  always #5 clk = ~clk;

  free_list_allocator dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .free_valid(free_valid), .free_ready(free_ready), .free_addr(free_addr),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec(vec),
    .rewind(rewind), .rewind_addr(rewind_addr), .rewind_count(rewind_count),
    .free_count(free_count), .empty(empty), .full(full), .err(err)
  );

  int checks = 0, failures = 0;
  int fl[$];
  int ck_q[$];
  bit allocated[N];
  int succ[N];
  bit bubble_m = 1'b0;
  bit err_m = 1'b0;
  vec_t vz = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = (fl.size() > 0) && !bubble_m;
    chk("alloc_ready", alloc_ready, rdy);
    if (rdy) chk("alloc_addr", alloc_addr, fl[0]);
    chk("free_count", free_count, fl.size());
    chk("empty", empty, fl.size() == 0);
    chk("full", full, fl.size() == N);
    chk("err", err, err_m);
  endtask

  task automatic step(input bit a, input bit f, input int fa, input bit v, input vec_t vd,
                      input bit r, input int ra, input int rc);
    bit fire_a;
    int ch[$];
    int x;
    check_outputs();
    alloc_valid = a; free_valid = f; free_addr = fa[3:0];
    vec_valid = v; vec = vd; rewind = r; rewind_addr = ra[3:0]; rewind_count = rc[4:0];
    #1;
    chk("free_ready", free_ready, !v && !r);
    chk("vec_ready", vec_ready, !r);
    fire_a = a && (fl.size() > 0) && !bubble_m && !r;
    @(posedge clk);
    if (r) begin
      fl = ck_q;
      for (int i = 0; i < N; i++) allocated[i] = 1'b1;
      foreach (fl[j]) allocated[fl[j]] = 1'b0;
      bubble_m = 1'b1;
    end else begin
      bubble_m = 1'b0;
      if (fire_a) begin
        x = fl[0];
        succ[x] = (fl.size() > 1) ? fl[1] : -1;
        allocated[x] = 1'b1;
        void'(fl.pop_front());
      end
      if (v) begin
        x = int'(vd.head);
        for (int k = 0; k < int'(vd.count); k++) begin
          ch.push_back(x);
          x = (x >= 0) ? succ[x] : -1;
        end
        for (int k = ch.size() - 1; k >= 0; k--) begin
          fl.push_front(ch[k]);
          allocated[ch[k]] = 1'b0;
        end
      end else if (f) begin
        if (fl.size() >= N) begin
`ifdef ALLOC_ERR_EN
          err_m = 1'b1;
`endif
        end else begin
          fl.push_front(fa);
          allocated[fa] = 1'b0;
        end
      end
    end
    @(negedge clk);
    alloc_valid = 1'b0; free_valid = 1'b0; vec_valid = 1'b0; rewind = 1'b0;
  endtask

  task automatic do_alloc();  step(1'b1, 1'b0, 0, 1'b0, vz, 1'b0, 0, 0); endtask
  task automatic do_idle();   step(1'b0, 1'b0, 0, 1'b0, vz, 1'b0, 0, 0); endtask
  task automatic do_free(input int fa); step(1'b0, 1'b1, fa, 1'b0, vz, 1'b0, 0, 0); endtask

  function automatic int pick_alloc();
    int q[$];
    for (int i = 0; i < N; i++) if (allocated[i]) q.push_back(i);
    if (q.size() == 0) return -1;
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  // chain of allocated entries linked through their remembered successors
  function automatic vec_t make_chain(input int h);
    int ch[$];
    int len, s;
    bit dup;
    vec_t vd;
    len = $urandom_range(1, 4);
    ch.push_back(h);
    while (ch.size() < len) begin
      s = succ[ch[ch.size() - 1]];
      if (s < 0) break;
      if (!allocated[s]) break;
      dup = 1'b0;
      foreach (ch[j]) if (ch[j] == s) dup = 1'b1;
      if (dup) break;
      ch.push_back(s);
    end
    vd.head   = 4'(ch[0]);
    vd.second = (ch.size() > 1) ? 4'(ch[1]) : 4'($urandom_range(0, N - 1));
    vd.tail   = 4'(ch[ch.size() - 1]);
    vd.count  = 5'(ch.size());
    return vd;
  endfunction

  task automatic do_ckpt();
    int h, c, n;
    if (bubble_m || fl.size() < 2) return;
    ck_q = fl;
    h = fl[0];
    c = fl.size();
    n = $urandom_range(1, (c < 3) ? c : 3);
    repeat (n) do_alloc();
    step(1'b0, 1'b0, 0, 1'b0, vz, 1'b1, h, c);
    chk("rewind_bubble", alloc_ready, 1'b0);
    do_idle();
    chk("rewind_head", alloc_addr, h);
    chk("rewind_count", free_count, c);
  endtask

  initial begin
    int a, op, fa;
    vec_t vd;
    for (int i = 0; i < N; i++) begin
      fl.push_back(i);
      allocated[i] = 1'b0;
      succ[i] = -1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", alloc_ready, 1'b1);
    chk("rst_addr", alloc_addr, 4'd0);
    chk("rst_count", free_count, 5'd16);
    chk("rst_full", full, 1'b1);
    chk("rst_empty", empty, 1'b0);
    chk("rst_err", err, 1'b0);

    // drain the whole list in order
    for (int i = 0; i < N; i++) begin
      chk("drain_addr", alloc_addr, i);
      do_alloc();
    end
    chk("drain_empty", empty, 1'b1);
    chk("drain_ready", alloc_ready, 1'b0);

    // frees while empty, combined alloc+free, chain splice
    do_free(5);
    do_free(3);
    chk("free_head", alloc_addr, 4'd3);
    step(1'b1, 1'b1, 9, 1'b0, vz, 1'b0, 0, 0);
    chk("af_head", alloc_addr, 4'd9);
    chk("af_count", free_count, 5'd2);
    vd = '{head: 4'd10, second: 4'd11, tail: 4'd12, count: 5'd3};
    step(1'b0, 1'b0, 0, 1'b1, vd, 1'b0, 0, 0);
    chk("vec_count", free_count, 5'd5);
    chk("vec_head", alloc_addr, 4'd10);
    do_alloc(); chk("seq1", alloc_addr, 4'd11);
    do_alloc(); chk("seq2", alloc_addr, 4'd12);
    do_alloc(); chk("seq3", alloc_addr, 4'd9);
    do_alloc(); chk("seq4", alloc_addr, 4'd5);

    // refill partially, then randomized traffic with periodic checkpoint/rewind
    for (int i = 0; i < 8; i++) do_free(pick_alloc());
    for (int it = 0; it < 500; it++) begin
      if (it % 25 == 24) begin
        do_ckpt();
      end else begin
        a  = ((fl.size() > 0) && ($urandom_range(0, 3) != 0)) ? 1 : 0;
        op = $urandom_range(0, 7);
        fa = pick_alloc();
        if (op >= 6 && fa >= 0) begin
          vd = make_chain(fa);
          step(a[0], 1'b0, 0, 1'b1, vd, 1'b0, 0, 0);
        end else if (op >= 3 && fa >= 0) begin
          step(a[0], 1'b1, fa, 1'b0, vz, 1'b0, 0, 0);
        end else begin
          step(a[0], 1'b0, 0, 1'b0, vz, 1'b0, 0, 0);
        end
      end
    end

`ifdef ALLOC_ERR_EN
    // return everything, then an illegal free while full
    for (int i = 0; i < 2 * N; i++) begin
      fa = pick_alloc();
      if (fa >= 0) do_free(fa);
    end
    do_free(0);
    chk("err_set", err, 1'b1);
    chk("err_count", free_count, 5'd16);
    do_idle();
    chk("err_sticky", err, 1'b1);
`endif
    do_idle();
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
